// File: rtl/isp8_arb_pkg.sv
// Shared encodings and default sizes for the ISP8 scratchpad arbiter.
package isp8_arb_pkg;

   localparam int DEF_DW = 8;
   localparam int DEF_AW = 5;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      ACC  = 2'b01,
      RSP  = 2'b10
   } state_t;

   typedef enum logic {
      CPU  = 1'b0,
      HOST = 1'b1
   } owner_t;

endpackage

// File: rtl/isp8_scratch_ram.sv
// Scratchpad storage: synchronous write, combinational read, never reset.
module isp8_scratch_ram
   import isp8_arb_pkg::*;
#(
   parameter int DW = DEF_DW,
   parameter int AW = DEF_AW
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_addr,
   input  logic [DW-1:0] i_wdata,
   output logic [DW-1:0] o_rdata
);

   logic [DW-1:0] r_mem [0:(2**AW)-1];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/isp8_scratch_arb.sv
// Two-port (CPU/host) arbiter in front of a single scratchpad, one access in flight.
// Define ARB_FAIR_EN for round-robin tie-breaking; otherwise the CPU wins every tie.
module isp8_scratch_arb
   import isp8_arb_pkg::*;
#(
   parameter int DW = DEF_DW,
   parameter int AW = DEF_AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] cpu_addr,
   input  logic          cpu_rd,
   input  logic          cpu_wr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_ready,
   output logic [DW-1:0] cpu_rdata,
   input  logic          host_req,
   input  logic          host_we,
   input  logic [AW-1:0] host_addr,
   input  logic [DW-1:0] host_wdata,
   output logic          host_ack,
   output logic [DW-1:0] host_rdata,
   output logic          busy
);

   state_t        r_state;
   owner_t        r_owner;
   logic          r_we;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_wdata;
   logic          r_cpu_ready;
   logic          r_host_ack;
   logic [DW-1:0] r_cpu_rdata;
   logic [DW-1:0] r_host_rdata;
`ifdef ARB_FAIR_EN
   owner_t        r_last_grant;
`endif

   logic          w_cpu_req;
   owner_t        w_grant;
   logic          w_win_we;
   logic [AW-1:0] w_win_addr;
   logic [DW-1:0] w_win_wdata;
   logic          w_ram_we;
   logic [DW-1:0] w_ram_rdata;

   // A CPU request with both rd and wr high is treated as a write.
   assign w_cpu_req = cpu_rd | cpu_wr;

   always_comb begin
      w_grant = CPU;
      if (w_cpu_req && host_req) begin
`ifdef ARB_FAIR_EN
         w_grant = (r_last_grant == CPU) ? HOST : CPU;
`else
         w_grant = CPU;
`endif
      end else if (host_req) begin
         w_grant = HOST;
      end
   end

   assign w_win_we    = (w_grant == CPU) ? cpu_wr    : host_we;
   assign w_win_addr  = (w_grant == CPU) ? cpu_addr  : host_addr;
   assign w_win_wdata = (w_grant == CPU) ? cpu_wdata : host_wdata;

   // Gate on rst so a write racing a reset edge is never committed.
   assign w_ram_we = (r_state == ACC) && r_we && !rst;

   isp8_scratch_ram #(.DW(DW), .AW(AW)) u_ram (
      .clk     (clk),
      .i_we    (w_ram_we),
      .i_addr  (r_addr),
      .i_wdata (r_wdata),
      .o_rdata (w_ram_rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_owner      <= HOST;
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_cpu_ready  <= 1'b0;
         r_host_ack   <= 1'b0;
         r_cpu_rdata  <= '0;
         r_host_rdata <= '0;
`ifdef ARB_FAIR_EN
         r_last_grant <= HOST;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (w_cpu_req || host_req) begin
                  r_state <= ACC;
                  r_owner <= w_grant;
                  r_we    <= w_win_we;
                  r_addr  <= w_win_addr;
                  r_wdata <= w_win_wdata;
`ifdef ARB_FAIR_EN
                  r_last_grant <= w_grant;
`endif
               end
            end
            ACC: begin
               r_state <= RSP;
               if (!r_we) begin
                  if (r_owner == CPU) begin
                     r_cpu_rdata <= w_ram_rdata;
                  end else begin
                     r_host_rdata <= w_ram_rdata;
                  end
               end
               r_cpu_ready <= (r_owner == CPU);
               r_host_ack  <= (r_owner == HOST);
            end
            RSP: begin
               r_state     <= IDLE;
               r_cpu_ready <= 1'b0;
               r_host_ack  <= 1'b0;
            end
            default: begin
               r_state     <= IDLE;
               r_cpu_ready <= 1'b0;
               r_host_ack  <= 1'b0;
            end
         endcase
      end
   end

   assign cpu_ready  = r_cpu_ready;
   assign host_ack   = r_host_ack;
   assign cpu_rdata  = r_cpu_rdata;
   assign host_rdata = r_host_rdata;
   assign busy       = (r_state != IDLE);

endmodule
